// File: rtl/breakout_pkg.sv
// Shared game-controller types and brick mask constants, also used by the
// collision detector and the drawing logic.
package breakout_pkg;

    localparam int NUM_BLOCKS = 16;
    localparam int IDX_W      = $clog2(NUM_BLOCKS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_LOST      = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } game_state_t;

    localparam logic [NUM_BLOCKS-1:0] BLOCKS_NONE = 16'h0000;
    localparam logic [NUM_BLOCKS-1:0] BLOCKS_ALL  = 16'hFFFF;
    localparam logic [NUM_BLOCKS-1:0] BLOCKS_ROW0 = 16'h00FF;
    localparam logic [NUM_BLOCKS-1:0] BLOCKS_ROW1 = 16'hFF00;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/breakout_game_ctrl_prio_enc.sv
// Brick hit priority encoder: lowest set bit of the mask wins.
import breakout_pkg::*;

module block_prio_enc (
    input  logic [NUM_BLOCKS-1:0] mask,
    output logic [IDX_W-1:0]      idx,
    output logic                  valid
);

    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end else begin
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: brick hit-point table, score, lives and game flow.
// Accepts at most one brick hit per video frame.
import breakout_pkg::*;

module breakout_game_ctrl #(
    parameter int HITS_PER_BLOCK   = 2,
    parameter int LIVES_INIT       = 3,
    parameter int POINTS_PER_BRICK = 10,
    parameter int SERVE_FRAMES     = 60
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  start_btn,
    input  logic                  collision_det,
    input  logic [NUM_BLOCKS-1:0] blocks_hit,
    input  logic                  ball_lost,
    output logic [NUM_BLOCKS-1:0] blocks_alive,
    output logic                  bounce_req,
    output logic                  ball_release,
    output logic [15:0]           score,
    output logic [2:0]            lives,
    output logic                  game_over,
    output logic                  game_won
);

    localparam int          SC_W    = $clog2(SERVE_FRAMES);
    localparam logic [1:0]  HP_INIT = 2'(HITS_PER_BLOCK);
    localparam logic [15:0] PTS     = 16'(POINTS_PER_BRICK);

    game_state_t             state_r, state_s;
    logic                    start_prev_r, hit_lock_r;
    logic [SC_W-1:0]         serve_cnt_r;
    logic [1:0]              hp_r [NUM_BLOCKS];
    logic                    start_edge_s, serve_done_s, reload_s, hit_valid_s;
    logic [NUM_BLOCKS-1:0]   eff_mask_s;
    logic [IDX_W-1:0]        hit_idx_s;

    assign start_edge_s = start_btn & ~start_prev_r;
    assign serve_done_s = frame_tick && (serve_cnt_r == SC_W'(SERVE_FRAMES - 1));

    // Only live bricks, only in PLAY, only while unlocked this frame
    always_comb begin
        eff_mask_s = BLOCKS_NONE;
        if ((state_r == ST_PLAY) && collision_det && !hit_lock_r) begin
            eff_mask_s = blocks_hit & blocks_alive;
        end else begin
            eff_mask_s = BLOCKS_NONE;
        end
    end

    block_prio_enc u_prio (
        .mask  (eff_mask_s),
        .idx   (hit_idx_s),
        .valid (hit_valid_s)
    );

    // Next-state logic
    always_comb begin
        state_s  = state_r;
        reload_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (start_edge_s) begin
                    state_s  = ST_SERVE;
                    reload_s = 1'b1;
                end else begin
                    state_s  = state_r;
                end
            end
            ST_SERVE: begin
                if (serve_done_s) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_SERVE;
                end
            end
            ST_PLAY: begin
                if (blocks_alive == BLOCKS_NONE) begin
                    state_s = ST_WIN;
                end else if (ball_lost) begin
                    state_s = ST_LOST;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_LOST: begin
                if (lives == 3'd1) begin
                    state_s = ST_GAME_OVER;
                end else begin
                    state_s = ST_SERVE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and start-button edge history
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            start_prev_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            start_prev_r <= start_btn;
        end
    end

    // Registered control outputs derived from the next state
    always_ff @(posedge pclk) begin
        if (rst) begin
            bounce_req   <= 1'b0;
            ball_release <= 1'b0;
            game_over    <= 1'b0;
            game_won     <= 1'b0;
        end else begin
            bounce_req   <= hit_valid_s;
            ball_release <= (state_s == ST_PLAY);
            game_over    <= (state_s == ST_GAME_OVER);
            game_won     <= (state_s == ST_WIN);
        end
    end

    // Brick hit-point table, alive mask and score
    always_ff @(posedge pclk) begin
        if (rst || reload_s) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                hp_r[i] <= HP_INIT;
            end
            blocks_alive <= BLOCKS_ALL;
            score        <= 16'd0;
        end else if (hit_valid_s && (hp_r[hit_idx_s] != 2'd0)) begin
            hp_r[hit_idx_s] <= hp_r[hit_idx_s] - 2'd1;
            if (hp_r[hit_idx_s] == 2'd1) begin
                blocks_alive[hit_idx_s] <= 1'b0;
                score                   <= sat_add16(score, PTS);
            end
        end
    end

    // Lives: reloaded on a fresh game, one taken per LOST visit
    always_ff @(posedge pclk) begin
        if (rst || reload_s) begin
            lives <= 3'(LIVES_INIT);
        end else if ((state_r == ST_LOST) && (lives != 3'd0)) begin
            lives <= lives - 3'd1;
        end
    end

    // Serve frame counter and the one-hit-per-frame lock
    always_ff @(posedge pclk) begin
        if (rst) begin
            serve_cnt_r <= '0;
            hit_lock_r  <= 1'b0;
        end else begin
            if (state_r != ST_SERVE || serve_done_s) begin
                serve_cnt_r <= '0;
            end else if (frame_tick) begin
                serve_cnt_r <= serve_cnt_r + SC_W'(1);
            end
            if (state_r != ST_PLAY) begin
                hit_lock_r <= 1'b0;
            end else if (hit_lock_r) begin
                hit_lock_r <= ~frame_tick;
            end else if (hit_valid_s) begin
                hit_lock_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench: directed game scenarios plus random play, all compared
// each cycle against a behavioural game model.
module tb_breakout_game_ctrl;

    localparam int NB = 16, HITS = 2, LIVES0 = 3, PTS = 10, SFR = 60;

    logic          pclk = 1'b0;
    logic          rst, frame_tick, start_btn, collision_det, ball_lost;
    logic [NB-1:0] blocks_hit, blocks_alive;
    logic          bounce_req, ball_release, game_over, game_won;
    logic [15:0]   score;
    logic [2:0]    lives;

    int tests = 0, fails = 0, n_bounce = 0;

    always #5 pclk = ~pclk;

    breakout_game_ctrl dut (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
        .collision_det(collision_det), .blocks_hit(blocks_hit), .ball_lost(ball_lost),
        .blocks_alive(blocks_alive), .bounce_req(bounce_req), .ball_release(ball_release),
        .score(score), .lives(lives), .game_over(game_over), .game_won(game_won)
    );

    typedef enum {M_IDLE, M_SERVE, M_PLAY, M_LOST, M_OVER, M_WON} mstate_t;
    mstate_t m_st;
    int      m_hp [NB];
    int      m_score, m_lives, m_serve;
    bit      m_lock, m_prev, m_bounce;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] m_alive();
        logic [NB-1:0] a;
        for (int i = 0; i < NB; i++) a[i] = (m_hp[i] > 0);
        return a;
    endfunction

    task automatic m_reload();
        for (int i = 0; i < NB; i++) m_hp[i] = HITS;
        m_score = 0;
        m_lives = LIVES0;
        m_serve = 0;
    endtask

    // One clock edge of the game, from the rules, using current inputs
    task automatic model_step();
        bit edge_seen;
        int live_cnt;
        edge_seen = start_btn && !m_prev;
        m_prev    = start_btn;
        m_bounce  = 0;
        if (rst) begin
            m_reload();
            m_st = M_IDLE; m_lock = 0; m_prev = 0;
            return;
        end
        case (m_st)
            M_IDLE, M_OVER, M_WON: begin
                m_lock = 0;
                if (edge_seen) begin m_reload(); m_st = M_SERVE; end
            end
            M_SERVE: begin
                m_lock = 0;
                if (frame_tick) begin
                    if (m_serve == SFR - 1) begin m_serve = 0; m_st = M_PLAY; end
                    else m_serve++;
                end
            end
            M_PLAY: begin
                live_cnt = 0;
                for (int i = 0; i < NB; i++) if (m_hp[i] > 0) live_cnt++;
                if (m_lock) begin
                    if (frame_tick) m_lock = 0;
                end else if (collision_det) begin
                    for (int k = 0; k < NB; k++) begin
                        if (blocks_hit[k] && m_hp[k] > 0) begin
                            m_hp[k]--;
                            m_bounce = 1;
                            m_lock   = 1;
                            if (m_hp[k] == 0) m_score = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
                            break;
                        end
                    end
                end
                if (live_cnt == 0) m_st = M_WON;
                else if (ball_lost) m_st = M_LOST;
            end
            M_LOST: begin
                m_lock = 0;
                m_serve = 0;
                m_st = (m_lives == 1) ? M_OVER : M_SERVE;
                m_lives--;
            end
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check_eq("alive",   blocks_alive, m_alive());
        check_eq("bounce",  bounce_req,   m_bounce);
        check_eq("release", ball_release, m_st == M_PLAY);
        check_eq("score",   score,        m_score);
        check_eq("lives",   lives,        m_lives);
        check_eq("over",    game_over,    m_st == M_OVER);
        check_eq("won",     game_won,     m_st == M_WON);
    endtask

    task automatic cyc(input bit ft, input bit col, input logic [NB-1:0] hit,
                       input bit lost, input bit st, input bit r);
        @(negedge pclk);
        frame_tick = ft; collision_det = col; blocks_hit = hit;
        ball_lost = lost; start_btn = st; rst = r;
        @(posedge pclk);
        model_step();
        #1;
        compare_all();
        if (bounce_req) n_bounce++;
    endtask

    task automatic serve_out();
        repeat (SFR) cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [NB-1:0] one_hot;
        bit st_lvl;
        rst = 1'b1; frame_tick = 1'b0; start_btn = 1'b0;
        collision_det = 1'b0; blocks_hit = 16'h0000; ball_lost = 1'b0;
        m_reload(); m_st = M_IDLE; m_lock = 0; m_prev = 0; m_bounce = 0;

        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check_eq("rst_lives", lives, 32'd3);
        check_eq("rst_alive", blocks_alive, 32'hFFFF);

        // Start and serve into PLAY
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        serve_out();
        check_eq("play_release", ball_release, 32'd1);

        // Held collision gives one bounce only
        n_bounce = 0;
        repeat (5) cyc(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        check_eq("held_one_bounce", n_bounce, 32'd1);
        check_eq("held_alive", blocks_alive, 32'hFFFF);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        check_eq("kill0_alive", blocks_alive, 32'hFFFE);
        check_eq("kill0_score", score, 32'd10);

        // Two bits in one strobe: only brick 4 takes the hit
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        n_bounce = 0;
        cyc(1'b0, 1'b1, 16'h0110, 1'b0, 1'b0, 1'b0);
        check_eq("multi_bounce", n_bounce, 32'd1);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        check_eq("b8_first_hit", blocks_alive, 32'hFFFE);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        check_eq("b8_dead", blocks_alive, 32'hFEFE);

        // Dead-brick hit is ignored and leaves the lock open
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        n_bounce = 0;
        cyc(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        check_eq("dead_no_bounce", n_bounce, 32'd0);
        cyc(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        check_eq("after_dead_bounce", n_bounce, 32'd1);
        check_eq("after_dead_score", score, 32'd30);

        // Three lost balls end the game
        for (int n = 0; n < 3; n++) begin
            cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
            check_eq("lives_after_loss", lives, 32'(2 - n));
            if (n < 2) serve_out();
        end
        check_eq("game_over_flag", game_over, 32'd1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check_eq("restart_lives", lives, 32'd3);
        check_eq("restart_alive", blocks_alive, 32'hFFFF);
        check_eq("restart_over", game_over, 32'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        serve_out();

        // Clear every brick
        for (int i = 0; i < NB; i++) begin
            one_hot = 16'h0001 << i;
            repeat (2) begin
                cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
                cyc(1'b0, 1'b1, one_hot, 1'b0, 1'b0, 1'b0);
            end
        end
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check_eq("win_score", score, 32'd160);
        check_eq("win_flag", game_won, 32'd1);

        // Reset landing on a bounce cycle
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        serve_out();
        cyc(1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        check_eq("pre_rst_bounce", bounce_req, 32'd1);
        cyc(1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1);
        check_eq("rst_bounce", bounce_req, 32'd0);
        check_eq("rst_release", ball_release, 32'd0);
        check_eq("rst_score", score, 32'd0);

        // Random play against the model
        st_lvl = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 39) == 0) st_lvl = ~st_lvl;
            one_hot = 16'h0001 << $urandom_range(0, NB - 1);
            cyc(($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 1) == 0) ? one_hot : 16'($urandom),
                ($urandom_range(0, 399) == 0),
                st_lvl,
                ($urandom_range(0, 2999) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
